// File: rtl/pong_pkg.sv
// pong_pkg: state encodings, ball result codes and BCD helper shared by the pong stages
package pong_pkg;
  typedef enum logic [1:0] {
    NEWGAME = 2'b00,
    PLAY    = 2'b01,
    NEWBALL = 2'b10,
    OVER    = 2'b11
  } state_t;
  localparam logic [1:0] BALL_NONE   = 2'b00;
  localparam logic [1:0] BALL_P1     = 2'b01;
  localparam logic [1:0] BALL_P2     = 2'b10;
  localparam logic [1:0] BALL_REPLAY = 2'b11;
  function automatic logic [7:0] bcd_dec(input int tens, input int ones);
    return ones == 0 ? {4'(tens - 1), 4'd9} : {4'(tens), 4'(ones - 1)};
  endfunction
endpackage

// File: rtl/bcd2_counter.sv
// bcd2_counter: two-digit BCD up-counter with sync clear, saturating at 99
module bcd2_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] ones
);
  always_ff @(posedge clk)
    if (!rst_n || clr) begin
      tens <= '0;
      ones <= '0;
    end else if (inc && !(tens == 4'd9 && ones == 4'd9)) begin
      ones <= ones == 4'd9 ? 4'd0 : ones + 4'd1;
      tens <= ones == 4'd9 ? tens + 4'd1 : tens;
    end
endmodule

// File: rtl/pong_score_ctrl.sv
// pong_score_ctrl: game sequencing FSM, pause timer and BCD score keeping for both players
module pong_score_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_TENS    = 1,
  parameter int WIN_ONES    = 1,
  parameter int DELAY_TICKS = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       refr_tick,
  input  logic       start,
  input  logic       p1_miss,
  input  logic       p2_miss,
  output logic [3:0] dig3,
  output logic [3:0] dig2,
  output logic [3:0] dig1,
  output logic [3:0] dig0,
  output logic [1:0] ball,
  output logic       gra_still,
  output logic       game_over,
  output logic [1:0] state
);
  localparam int TW = DELAY_TICKS > 0 ? $clog2(DELAY_TICKS + 1) : 1;
  // score that wins on the next point, compared against pre-increment digits
  localparam logic [7:0] WIN_M1 = bcd_dec(WIN_TENS, WIN_ONES);
  state_t st, st_n;
  logic [TW-1:0] timer, timer_n;
  logic [1:0] ball_n;
  logic clr, inc1, inc2;
  bcd2_counter u_p1 (.clk(clk), .rst_n(rst_n), .clr(clr), .inc(inc1), .tens(dig3), .ones(dig2));
  bcd2_counter u_p2 (.clk(clk), .rst_n(rst_n), .clr(clr), .inc(inc2), .tens(dig1), .ones(dig0));
  always_comb begin
    st_n = st;
    ball_n = ball;
    clr = 1'b0;
    inc1 = 1'b0;
    inc2 = 1'b0;
    case (st)
      NEWGAME: if (start) begin
        clr = 1'b1;
        ball_n = BALL_NONE;
        st_n = PLAY;
      end
      PLAY: if (p1_miss && p2_miss) begin
        ball_n = BALL_REPLAY;
        st_n = NEWBALL;
      end else if (p2_miss) begin
        inc1 = 1'b1;
        ball_n = BALL_P1;
        st_n = {dig3, dig2} == WIN_M1 ? OVER : NEWBALL;
      end else if (p1_miss) begin
        inc2 = 1'b1;
        ball_n = BALL_P2;
        st_n = {dig1, dig0} == WIN_M1 ? OVER : NEWBALL;
      end
      NEWBALL: if (timer == '0 && start) st_n = PLAY;
      default: if (timer == '0) st_n = NEWGAME;
    endcase
    timer_n = (st_n != st && (st_n == NEWBALL || st_n == OVER)) ? TW'(DELAY_TICKS)
            : (refr_tick && timer != '0) ? timer - TW'(1) : timer;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      st <= NEWGAME;
      ball <= BALL_NONE;
      timer <= '0;
      gra_still <= 1'b1;
      game_over <= 1'b0;
    end else begin
      st <= st_n;
      ball <= ball_n;
      timer <= timer_n;
      gra_still <= st_n != PLAY;
      game_over <= st_n == OVER;
    end
  assign state = st;
endmodule

// File: tb/tb_pong_score_ctrl.sv
// tb_pong_score_ctrl: directed scoreboard bench for pong_score_ctrl (WIN 11, DELAY_TICKS 3)
module tb_pong_score_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, refr_tick = 1'b0, start = 1'b0, p1_miss = 1'b0, p2_miss = 1'b0;
  logic [3:0] dig3, dig2, dig1, dig0;
  logic [1:0] ball, state;
  logic gra_still, game_over;
  typedef struct {
    string tag;
    logic [21:0] val;
  } exp_t;
  exp_t q[$];
  int ncmp = 0, nerr = 0, s1 = 0, s2 = 0;
  logic [1:0] b = 2'b00;
  always #5 clk = ~clk;
  pong_score_ctrl #(.WIN_TENS(1), .WIN_ONES(1), .DELAY_TICKS(3)) dut (
    .clk(clk), .rst_n(rst_n), .refr_tick(refr_tick), .start(start),
    .p1_miss(p1_miss), .p2_miss(p2_miss),
    .dig3(dig3), .dig2(dig2), .dig1(dig1), .dig0(dig0),
    .ball(ball), .gra_still(gra_still), .game_over(game_over), .state(state)
  );
  function automatic logic [21:0] pk(int a, int c, logic [1:0] bl, logic [1:0] st);
    return {4'(a / 10), 4'(a % 10), 4'(c / 10), 4'(c % 10), bl, st != 2'b01, st == 2'b11, st};
  endfunction
  task automatic step(input string tag, input logic [1:0] st);
    exp_t e;
    logic [21:0] obs;
    q.push_back('{tag, pk(s1, s2, b, st)});
    @(posedge clk);
    #1;
    e = q.pop_front();
    obs = {dig3, dig2, dig1, dig0, ball, gra_still, game_over, state};
    ncmp++;
    assert (obs === e.val) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
    end
  endtask
  task automatic point(input bit p1_scores);
    int old;
    if (p1_scores) begin
      old = s1; s1++; b = 2'b01; p2_miss = 1'b1;
    end else begin
      old = s2; s2++; b = 2'b10; p1_miss = 1'b1;
    end
    step("point", old == 10 ? 2'b11 : 2'b10);
    p1_miss = 1'b0;
    p2_miss = 1'b0;
  endtask
  task automatic pause();
    refr_tick = 1'b1;
    start = 1'b1;
    repeat (3) step("pause", 2'b10);
    refr_tick = 1'b0;
    step("serve", 2'b01);
    start = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    step("rst0", 2'b00);
    step("rst1", 2'b00);
    rst_n = 1'b1;
    step("start", 2'b01);
    start = 1'b0;
    point(1);
    pause();
    repeat (9) begin
      point(0);
      pause();
    end
    repeat (9) begin
      point(1);
      pause();
    end
    point(1);
    refr_tick = 1'b1;
    start = 1'b1;
    repeat (3) step("over_hold", 2'b11);
    refr_tick = 1'b0;
    start = 1'b0;
    step("newgame", 2'b00);
    start = 1'b1;
    s1 = 0; s2 = 0; b = 2'b00;
    step("clear", 2'b01);
    start = 1'b0;
    p1_miss = 1'b1;
    p2_miss = 1'b1;
    b = 2'b11;
    step("both", 2'b10);
    p2_miss = 1'b0;
    step("miss_ignored", 2'b10);
    p1_miss = 1'b0;
    refr_tick = 1'b1;
    step("tick", 2'b10);
    refr_tick = 1'b0;
    rst_n = 1'b0;
    s1 = 0; s2 = 0; b = 2'b00;
    step("rst_mid", 2'b00);
    rst_n = 1'b1;
    start = 1'b1;
    step("restart", 2'b01);
    start = 1'b0;
    point(1);
    pause();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
